timer_dev: RTL
==============

// Module: timer_dev
// PURPOSE
//   Memory-mapped countdown timer on the processor bridge. The design instantiates it twice: Timer0 at 0x7f00..0x7f0b, Timer1 at 0x7f10..0x7f1b.
//   The bridge routes the Memory stage's PrAddr/PrWe/PrWD to this block. It returns read data on PrRD.
//   Its IRQ output drives one HWInt line into CP0.
//   Only aligned word accesses reach the block. The Memory stage raises exceptions for sub-word accesses and COUNT writes, so those never arrive.
// PARAMETERS
//   CNT_W   32   width of PRESET/COUNT (1..32); reads zero-extend to 32 bits
// PORTS
//   clk     in   1      system clock; all state changes on rising edge
//   reset   in   1      synchronous, active-high reset
//   Addr    in   30     word address [31:2]; only Addr[3:2] is decoded
//   WE      in   1      write strobe; already qualified by the bridge for this timer
//   Din     in   32     write data
//   Dout    out  32     read data, combinational from Addr[3:2]
//   IRQ     out  1      interrupt request = irq_flag & CTRL[3]
// BEHAVIOUR
//   Register map (Addr[3:2]):
//   - 0 CTRL: [0] Enable, [2:1] Mode, [3] IM. Read as {28'b0, CTRL[3:0]}.
//   - 1 PRESET: R/W.
//   - 2 COUNT: read-only; writes are ignored.
//   - 3: reads 0; writes are ignored.
//   Mode encoding: 2'b00 = one-shot, 2'b01 = periodic. 2'b10 and 2'b11 behave as 2'b00.
//   Reset: the next edge with reset=1 sets the following, so IRQ=0. Reset overrides writes.
//   - CTRL=0, PRESET=0, COUNT=0
//   - state=IDLE, irq_flag=0
//   CTRL write: on the edge with WE & Addr[3:2]==0, CTRL<=Din[3:0] and irq_flag<=0.
//   - This write wins over any same-edge FSM update of CTRL[0].
//   PRESET write: updates PRESET only. The running COUNT is unaffected until the next LOAD.
//   FSM states: IDLE, LOAD, CNT, INT. Transitions per edge:
//   - IDLE: if Enable, go to LOAD.
//   - LOAD: COUNT<=PRESET; go to CNT.
//   - CNT:
//     - If !Enable, go to IDLE; COUNT holds.
//     - Else if COUNT>1, COUNT<=COUNT-1.
//     - Else COUNT<=0, irq_flag<=1, go to INT.
//   - INT: go to IDLE.
//     - Mode 0: CTRL[0]<=0; irq_flag holds until a CTRL write or reset.
//     - Mode 1: irq_flag<=0, so the flag is high for exactly one cycle. Enable stays set, so the timer reloads.
//   Latency, with E0 = the edge that writes CTRL.Enable=1 and PRESET=N:
//   - N>=1: COUNT==N after E2, and IRQ rises after edge E(N+2).
//   - N=0 behaves as N=1.
//   Mode 1 period: the interval between IRQ pulses is N+3 cycles for N>=1.
//   Clearing Enable mid-count: the FSM goes to IDLE on the next edge and COUNT freezes. Re-enabling reloads from PRESET.
//   Masking: IM=0 masks IRQ only. irq_flag still sets, and IRQ appears if IM is later set without a CTRL write.
//     (A CTRL write always clears irq_flag, so setting IM via a CTRL write cannot expose a pending flag.)
//   Wrap-around: the counter never underflows; COUNT stops at 0.
//   Dout has no clock latency. Reads have no side effects.
// TESTING
//   1. Reset, then read all 4 addresses -> Dout=0 everywhere, IRQ=0.
//   2. PRESET=5, CTRL=4'b1001 (mode 0, IM=1) -> IRQ rises 7 edges after the CTRL write.
//      COUNT reads 5,4,3,2,1,0; then CTRL[0]=0 and IRQ stays high. Write CTRL=0 -> IRQ=0 next cycle.
//   3. PRESET=3, CTRL=4'b1011 (mode 1) -> IRQ is a 1-cycle pulse every 6 cycles over 4 periods.
//      A mid-run PRESET=10 write takes effect at the next reload.
//   4. PRESET=100, enable, then clear Enable at COUNT=50 -> COUNT holds 50 and IRQ is never asserted.
//      Re-enable -> COUNT reloads 100.
//   5. Write COUNT=0x1234 and addr 3 -> no state change.
//      Assert reset during CNT with COUNT=20 -> all registers 0 and state IDLE after the edge.
//   6. CTRL=4'b0001 (IM=0), PRESET=1 -> irq_flag sets but IRQ stays 0.
//      Mode-0 INT edge coinciding with a CTRL write of 4'b1001 -> Enable stays 1 and irq_flag clears.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and periodic modes.
// CTRL/PRESET/COUNT are decoded from Addr[3:2], and IRQ is the flag gated by CTRL.IM.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_ctrl;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_irq_flag;

  logic w_enable;
  logic w_periodic;
  logic w_im;
  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_load;
  logic w_dec;
  logic w_expire;
  logic w_int_done;
  logic w_unused_addr;

  assign w_enable      = r_ctrl[0];
  assign w_periodic    = (r_ctrl[2:1] == 2'b01);
  assign w_im          = r_ctrl[3];
  assign w_wr_ctrl     = WE && (Addr[3:2] == 2'd0);
  assign w_wr_preset   = WE && (Addr[3:2] == 2'd1);
  assign w_unused_addr = ^Addr[31:4];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_enable) w_state_next = S_LOAD;
      S_LOAD: w_state_next = S_CNT;
      S_CNT: begin
        if (!w_enable)                   w_state_next = S_IDLE;
        else if (r_count <= CNT_W'(1))   w_state_next = S_INT;
      end
      S_INT:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs steering the datapath.
  always_comb begin
    w_load     = (r_state == S_LOAD);
    w_int_done = (r_state == S_INT);
    w_dec      = 1'b0;
    w_expire   = 1'b0;
    if (r_state == S_CNT && w_enable) begin
      if (r_count > CNT_W'(1)) w_dec    = 1'b1;
      else                     w_expire = 1'b1;
    end
  end

  // Datapath; a CTRL write takes priority over FSM updates of Enable and the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_preset) r_preset <= Din[CNT_W-1:0];

      if (w_load)        r_count <= r_preset;
      else if (w_dec)    r_count <= r_count - CNT_W'(1);
      else if (w_expire) r_count <= '0;

      if (w_wr_ctrl) begin
        r_ctrl     <= Din[3:0];
        r_irq_flag <= 1'b0;
      end else begin
        if (w_expire) r_irq_flag <= 1'b1;
        if (w_int_done) begin
          if (w_periodic) r_irq_flag <= 1'b0;
          else            r_ctrl[0]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    Dout = '0;
    unique case (Addr[3:2])
      2'd0: Dout = {28'b0, r_ctrl};
      2'd1: Dout = 32'(r_preset);
      2'd2: Dout = 32'(r_count);
      2'd3: Dout = '0;
      default: Dout = '0;
    endcase
  end

  assign IRQ = r_irq_flag & w_im;

endmodule
